shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter: FIRST_PRIO, 0, requester that wins the first contended cycle after reset (0 or 1).
REQ-002 Parameter: CNT_W, 16, width of the accepted-transaction counter.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req0_valid  input  1  requester 0 presents an operation.
REQ-007 req0_X  input  32  requester 0 operand.
REQ-008 req0_shamt  input  5  requester 0 shift amount.
REQ-009 req0_left  input  1  requester 0 direction (1 = left, 0 = right).
REQ-010 req0_log  input  1  requester 0 type (1 = logical, 0 = arithmetic).
REQ-011 req0_ready  output  1  requester 0 operation accepted this cycle when high together with req0_valid.
REQ-012 req1_valid, req1_X, req1_shamt, req1_left, req1_log, req1_ready  same directions, widths and meanings as REQ-006..REQ-011, for requester 1.
REQ-013 rsp_valid  output  1  result register holds an undelivered result.
REQ-014 rsp_id  output  1  index of the requester that owns the result.
REQ-015 rsp_result  output  32  shifted value.
REQ-016 rsp_ready  input  1  consumer accepts the result this cycle.
REQ-017 xfer_count  output  CNT_W  number of accepted requests, modulo 2^CNT_W.

Function
REQ-018 The block SHALL contain one combinational 32-bit barrel shifter shared by both requesters; there SHALL be no second shift datapath.
REQ-019 Shift semantics:
- left: zero fill, for either value of req_log.
- right logical: zero fill.
- right arithmetic: fill with operand bit 31.
- shamt 0: operand returned unchanged.
REQ-020 Output register states are EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-021 can_accept = EMPTY, or (FULL and rsp_ready).
REQ-022 Grant: if exactly one reqN_valid, that requester is granted; if both, the requester other than last_served is granted; if neither, no grant.
REQ-023 reqN_ready = can_accept and (requester N is granted); it is combinational. At most one ready is high per cycle. Ready is never high for a requester whose valid is low.
REQ-024 Acceptance in cycle N: on the following edge, rsp_result captures the shifter output for the granted operands, rsp_id captures the grant index, rsp_valid=1. The result is visible in cycle N+1 (latency 1).
REQ-025 Delivery (FULL and rsp_ready) with no acceptance in the same cycle SHALL go to EMPTY. Delivery and acceptance in the same cycle SHALL stay FULL, loaded with the new result (full throughput, one per cycle).
REQ-026 While FULL and rsp_ready=0, rsp_result and rsp_id SHALL hold stable and both reqN_ready SHALL be 0.
REQ-027 last_served updates to the grant index only on acceptance. It is unchanged on cycles where a request waits because of backpressure.
REQ-028 Fairness: with both valid continuously and rsp_ready=1, grants SHALL alternate 0,1,0,1,...; neither requester waits more than one accepted transaction.
REQ-029 xfer_count increments by 1 on each acceptance and wraps from 2^CNT_W-1 to 0.
REQ-030 Requester operands are sampled only in the accepting cycle; later changes SHALL not affect a captured result.

Reset
REQ-031 Reset SHALL be asynchronous and take effect on assertion without a clock edge. Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, xfer_count=0, and last_served set so that FIRST_PRIO wins the first contention.
REQ-032 Reset asserted while FULL SHALL discard the pending result; no response is delivered for it.
REQ-033 reqN_ready SHALL be 0 while reset is asserted.

Verification
REQ-034 Req0 X=0x80000000, shamt=4, left=0, log=0, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=0xF8000000. Same operands with log=1 -> 0x08000000.
REQ-035 Req1 X=0x0000_00FF, shamt=31, left=1 -> rsp_result=0x80000000. Same operand with shamt=0, left=0, log=0 -> 0x000000FF.
REQ-036 Both requesters valid for 6 cycles, FIRST_PRIO=0, rsp_ready=1 -> rsp_id sequence 0,1,0,1,0,1 and xfer_count=6.
REQ-037 Hold rsp_ready=0 for 3 cycles while FULL, with both requesters valid -> both readys 0 and rsp_result unchanged. Raise rsp_ready -> a new result is loaded on the next edge.
REQ-038 Assert reset asynchronously (mid-cycle) while FULL -> rsp_valid falls before the next clock edge and xfer_count=0. After release, the first contended grant goes to FIRST_PRIO.
REQ-039 Preload xfer_count to 0xFFFF with CNT_W=16 (via 65535 accepts) -> one more accept gives xfer_count=0.

Source files
------------

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of one shared 32-bit barrel shifter, with a
// single-entry output register and an accepted-transaction counter.
module shift_arbiter #(
    parameter logic FIRST_PRIO = 1'b0,
    parameter int   CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [31:0]      req0_X,
    input  logic [4:0]       req0_shamt,
    input  logic             req0_left,
    input  logic             req0_log,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_X,
    input  logic [4:0]       req1_shamt,
    input  logic             req1_left,
    input  logic             req1_log,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [31:0]      rsp_result,
    input  logic             rsp_ready,
    output logic [CNT_W-1:0] xfer_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic              r_lastServed;
    logic              r_id;
    logic [31:0]       r_result;
    logic [CNT_W-1:0]  r_count;

    logic              w_anyValid;
    logic              w_grantIdx;
    logic              w_canAccept;
    logic              w_accept;
    logic [31:0]       w_x;
    logic [4:0]        w_shamt;
    logic              w_left;
    logic              w_log;
    logic              w_fill;
    logic [31:0]       w_shIn;
    logic [63:0]       w_wide;
    logic [31:0]       w_shOut;
    logic [31:0]       w_result;

    // On contention the requester that was not served last wins.
    assign w_anyValid  = req0_valid | req1_valid;
    assign w_grantIdx  = (req0_valid && req1_valid) ? ~r_lastServed : req1_valid;
    assign w_canAccept = (r_state == EMPTY) || rsp_ready;
    assign w_accept    = w_canAccept && w_anyValid && !reset;
    assign req0_ready  = w_accept && !w_grantIdx;
    assign req1_ready  = w_accept && w_grantIdx;

    assign w_x     = w_grantIdx ? req1_X     : req0_X;
    assign w_shamt = w_grantIdx ? req1_shamt : req0_shamt;
    assign w_left  = w_grantIdx ? req1_left  : req0_left;
    assign w_log   = w_grantIdx ? req1_log   : req0_log;
    assign w_fill  = !w_left && !w_log && w_x[31];

    // Left shifts reuse the single right shifter by bit-reversing in and out.
    always_comb begin
        w_shIn = w_x;
        if (w_left) begin
            for (int i = 0; i < 32; i++) begin
                w_shIn[i] = w_x[31-i];
            end
        end
    end

    assign w_wide  = {{32{w_fill}}, w_shIn} >> w_shamt;
    assign w_shOut = w_wide[31:0];

    always_comb begin
        w_result = w_shOut;
        if (w_left) begin
            for (int i = 0; i < 32; i++) begin
                w_result[i] = w_shOut[31-i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            EMPTY: if (w_accept) w_stateNext = FULL;
            FULL:  if (!w_accept && rsp_ready) w_stateNext = EMPTY;
            default: w_stateNext = EMPTY;
        endcase
    end

    // Reset value of last-served makes FIRST_PRIO win the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lastServed <= ~FIRST_PRIO;
            r_id         <= 1'b0;
            r_result     <= 32'h0;
            r_count      <= '0;
        end else if (w_accept) begin
            r_lastServed <= w_grantIdx;
            r_id         <= w_grantIdx;
            r_result     <= w_result;
            r_count      <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign rsp_valid  = (r_state == FULL);
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign xfer_count = r_count;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: a small reference model predicts readys,
// grants and results; expected responses queue up and are checked on output.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_left, req0_log, req0_ready;
    logic [31:0] req0_X;
    logic [4:0]  req0_shamt;
    logic        req1_valid, req1_left, req1_log, req1_ready;
    logic [31:0] req1_X;
    logic [4:0]  req1_shamt;
    logic        rsp_valid, rsp_id, rsp_ready;
    logic [31:0] rsp_result;
    logic [15:0] xfer_count;

    int          vectors = 0;
    int          miscompares = 0;

    logic        mFull;
    logic        mLast;
    logic [15:0] mCount;
    logic [32:0] expQ[$];
    logic [31:0] heldResult;

    shift_arbiter #(.FIRST_PRIO(1'b0), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_X(req0_X), .req0_shamt(req0_shamt),
        .req0_left(req0_left), .req0_log(req0_log), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_X(req1_X), .req1_shamt(req1_shamt),
        .req1_left(req1_left), .req1_log(req1_log), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_ready(rsp_ready), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] shiftRef(input logic [31:0] x, input logic [4:0] sh,
                                             input logic left, input logic lg);
        logic [63:0] wide;
        if (left) return x << sh;
        wide = {(lg ? 32'h0 : {32{x[31]}}), x};
        wide = wide >> sh;
        return wide[31:0];
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mFull  = 1'b0;
        mLast  = 1'b1;
        mCount = 16'h0;
        expQ.delete();
    endtask

    task automatic checkOutput();
        checkEq("rsp_valid", {31'h0, rsp_valid}, {31'h0, mFull});
        if (mFull) begin
            if (expQ.size() == 0) begin
                checkEq("scoreboard empty", 32'h1, 32'h0);
            end else begin
                checkEq("rsp_id", {31'h0, rsp_id}, {31'h0, expQ[0][32]});
                checkEq("rsp_result", rsp_result, expQ[0][31:0]);
            end
        end
        checkEq("xfer_count", {16'h0, xfer_count}, {16'h0, mCount});
    endtask

    // Called at a falling edge: drive, check readys, update model, then check outputs.
    task automatic applyStimulus(
        input logic v0, input logic [31:0] x0, input logic [4:0] s0, input logic l0, input logic g0,
        input logic v1, input logic [31:0] x1, input logic [4:0] s1, input logic l1, input logic g1,
        input logic rr);
        logic canAcc, grant, r0, r1;
        req0_valid = v0; req0_X = x0; req0_shamt = s0; req0_left = l0; req0_log = g0;
        req1_valid = v1; req1_X = x1; req1_shamt = s1; req1_left = l1; req1_log = g1;
        rsp_ready  = rr;
        #1;
        canAcc = !mFull || rr;
        grant  = (v0 && v1) ? ~mLast : v1;
        r0 = canAcc && v0 && !grant;
        r1 = canAcc && v1 && grant;
        checkEq("req0_ready", {31'h0, req0_ready}, {31'h0, r0});
        checkEq("req1_ready", {31'h0, req1_ready}, {31'h0, r1});
        if (mFull && rr && expQ.size() > 0) void'(expQ.pop_front());
        if (r0) expQ.push_back({1'b0, shiftRef(x0, s0, l0, g0)});
        if (r1) expQ.push_back({1'b1, shiftRef(x1, s1, l1, g1)});
        if (r0 || r1) begin
            mCount = mCount + 16'h1;
            mLast  = grant;
        end
        mFull = r0 || r1 || (mFull && !rr);
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_X = 32'h0; req0_shamt = 5'd0; req0_left = 1'b0; req0_log = 1'b0;
        req1_valid = 1'b1; req1_X = 32'h0; req1_shamt = 5'd0; req1_left = 1'b0; req1_log = 1'b0;
        rsp_ready = 1'b1;
        modelReset();
        #1;
        checkEq("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkEq("reset rsp_id", {31'h0, rsp_id}, 32'h0);
        checkEq("reset rsp_result", rsp_result, 32'h0);
        checkEq("reset xfer_count", {16'h0, xfer_count}, 32'h0);
        checkEq("reset req0_ready", {31'h0, req0_ready}, 32'h0);
        checkEq("reset req1_ready", {31'h0, req1_ready}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] fairness with both requesters valid");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 32'h1000 + i, 5'(i), 1'b0, 1'b1,
                          1'b1, 32'hF000_0000 + i, 5'(i + 1), 1'b1, 1'b0, 1'b1);
            checkEq("fair id", {31'h0, rsp_id}, 32'(i % 2));
        end
        checkEq("fair count", {16'h0, xfer_count}, 32'd6);

        $display("[TB] shift semantics");
        applyStimulus(1'b1, 32'h8000_0000, 5'd4, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkEq("right arith", rsp_result, 32'hF800_0000);
        checkEq("right arith id", {31'h0, rsp_id}, 32'h0);
        applyStimulus(1'b1, 32'h8000_0000, 5'd4, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkEq("right logic", rsp_result, 32'h0800_0000);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_00FF, 5'd31, 1'b1, 1'b0, 1'b1);
        checkEq("left 31", rsp_result, 32'h8000_0000);
        checkEq("left 31 id", {31'h0, rsp_id}, 32'h1);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_00FF, 5'd0, 1'b0, 1'b0, 1'b1);
        checkEq("shamt 0", rsp_result, 32'h0000_00FF);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h8765_4321, 5'd8, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 5'd3, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 5'd3, 1'b1, 1'b0, 1'b1);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'hC000_0001, 5'd1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        heldResult = 32'hE000_0000;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h1234_5678 + i, 5'd2, 1'b1, 1'b0,
                          1'b1, 32'h8765_4321 + i, 5'd5, 1'b0, 1'b0, 1'b0);
            checkEq("held result", rsp_result, heldResult);
        end
        applyStimulus(1'b1, 32'h1234_5678, 5'd2, 1'b1, 1'b0, 1'b1, 32'h8765_4321, 5'd5, 1'b0, 1'b0, 1'b1);
        checkEq("after stall id", {31'h0, rsp_id}, 32'h1);
        checkEq("after stall result", rsp_result, 32'hFC3B_2A19);

        $display("[TB] asynchronous reset while full");
        applyStimulus(1'b1, 32'h0000_0F00, 5'd4, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        req1_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checkEq("async rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkEq("async xfer_count", {16'h0, xfer_count}, 32'h0);
        checkEq("async req0_ready", {31'h0, req0_ready}, 32'h0);
        checkEq("async req1_ready", {31'h0, req1_ready}, 32'h0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 32'h5, 5'd1, 1'b1, 1'b0, 1'b1, 32'h6, 5'd1, 1'b1, 1'b0, 1'b1);
        checkEq("first grant after reset", {31'h0, rsp_id}, 32'h0);

        $display("[TB] counter wrap");
        reset = 1'b1;
        #1;
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        req0_valid = 1'b1; req0_X = 32'h0000_0003; req0_shamt = 5'd1; req0_left = 1'b1; req0_log = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        repeat (65535) @(negedge clk);
        mCount = 16'hFFFF;
        mLast  = 1'b0;
        mFull  = 1'b1;
        expQ.push_back({1'b0, 32'h0000_0006});
        checkOutput();
        applyStimulus(1'b1, 32'h0000_0003, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkEq("count wrapped", {16'h0, xfer_count}, 32'h0);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
